// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - byte-masked register file, one write port, two registered read ports
// Optional same-edge write-to-read bypass: define REGFILE_BYPASS_EN.
module register_file_mp #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W/8-1:0]        wr_be,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [ADDR_W-1:0]          rd_addr1,
    input  logic [ADDR_W-1:0]          rd_addr2,
    output logic [DATA_W-1:0]          rd_data1,
    output logic [DATA_W-1:0]          rd_data2,
    output logic [(1<<ADDR_W)-1:0]     valid_mask
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int LANES = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data1;
    logic [DATA_W-1:0] r_rd_data2;
    logic [DEPTH-1:0]  r_valid;

    logic [DATA_W-1:0] w_merged;
    logic [DATA_W-1:0] w_rd1_next;
    logic [DATA_W-1:0] w_rd2_next;

    // Write value: enabled lanes from wr_data, the rest from the current entry.
    always_comb begin
        w_merged = r_mem[wr_addr];
        for (int i = 0; i < LANES; i++) begin
            if (wr_be[i]) begin
                w_merged[8*i +: 8] = wr_data[8*i +: 8];
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign w_rd1_next = (wr_en && (rd_addr1 == wr_addr)) ? w_merged : r_mem[rd_addr1];
    assign w_rd2_next = (wr_en && (rd_addr2 == wr_addr)) ? w_merged : r_mem[rd_addr2];
`else
    assign w_rd1_next = r_mem[rd_addr1];
    assign w_rd2_next = r_mem[rd_addr2];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
            r_rd_data1 <= '0;
            r_rd_data2 <= '0;
            r_valid    <= '0;
        end else begin
            r_rd_data1 <= w_rd1_next;
            r_rd_data2 <= w_rd2_next;
            if (wr_en) begin
                r_mem[wr_addr] <= w_merged;
                if (|wr_be) begin
                    r_valid[wr_addr] <= 1'b1;
                end
            end
        end
    end

    assign rd_data1   = r_rd_data1;
    assign rd_data2   = r_rd_data2;
    assign valid_mask = r_valid;
endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised register file: `DEPTH = 2**ADDR_W` entries of `DATA_W` bits, one byte-masked write port, two registered read ports, and a per-entry written-since-reset mask. It generalises the existing 4×16 register file and sits between decode (address fields) and the ALU operand latches of the core datapath. Read data is presented one cycle after the address. Optional same-cycle write-to-read bypass is compile-time selectable.

## Interface
- `DATA_W`, 16, entry width in bits; must be a multiple of 8 and ≥ 8.
- `ADDR_W`, 2, address width; `DEPTH = 2**ADDR_W`; range 1..6.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `wr_en` input 1: write strobe.
- `wr_addr` input ADDR_W: write address.
- `wr_be` input DATA_W/8: byte enables; bit i covers `wr_data[8i+7:8i]`.
- `wr_data` input DATA_W: write data.
- `rd_addr1` input ADDR_W: read port 1 address.
- `rd_addr2` input ADDR_W: read port 2 address.
- `rd_data1` output DATA_W: registered read data, port 1.
- `rd_data2` output DATA_W: registered read data, port 2.
- `valid_mask` output DEPTH: bit k = 1 once entry k has taken any write with nonzero `wr_be` since reset.

## Operation
- Storage: `DEPTH` × `DATA_W` flops. No RAM macro. Every entry is resettable.
- Write: on a rising edge with `reset`=0 and `wr_en`=1, each byte lane i with `wr_be[i]`=1 takes `wr_data` lane i. Lanes with `wr_be[i]`=0 keep their value.
- Write with `wr_be`=0: no storage change and no `valid_mask` change.
- `valid_mask[wr_addr]` sets on a write with any `wr_be` bit set. It is sticky until reset.
- Read: on every rising edge with `reset`=0, `rd_dataN <= entry[rd_addrN]`. Both ports read every cycle with no enable.
- Both ports may address the same entry. They return identical data.
- Same-cycle read/write to the same address: behaviour is set by `REGFILE_BYPASS_EN` (see Configuration).
- Reset: while `reset`=1 at a rising edge, all entries, `rd_data1`, `rd_data2` and `valid_mask` go to 0. Reset overrides a concurrent write, which is dropped.
- Reset mid-sequence: pending read results are discarded. The first read after reset deasserts returns 0 for every entry.
- Addresses are always in range because `DEPTH = 2**ADDR_W`. No wrap or error handling is needed.

## Timing
- Read latency: 1 cycle. Address applied before edge N gives data valid after edge N, held until edge N+1.
- Write latency: 1 cycle. A write at edge N is visible to a read sampled at edge N+1, whatever the config.
- Outputs change only on rising `clk`. There are no combinational input-to-output paths.
- Reset values: `rd_data1`=0, `rd_data2`=0, `valid_mask`=0, all entries 0.
- Back-to-back writes to the same address on consecutive cycles: the last one wins per byte lane.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - A read at edge N whose address equals `wr_addr` of a write at the same edge N returns the merged value.
  - Merged value: lane i = `wr_data` lane i when `wr_be[i]`=1, otherwise the old entry lane.
  - Applies to each port independently.
- `REGFILE_BYPASS_EN` undefined:
  - The same-edge read returns the pre-write entry value.
  - The new value appears on the next read.

## Test plan
- Reset behaviour: assert `reset` 2 cycles after writing 16'hFFFF to all 4 entries, then read all 4 -> every `rd_data` = 16'h0000 and `valid_mask` = 4'b0000.
- Reset priority: hold `reset`=1 with `wr_en`=1, `wr_addr`=2, `wr_data`=16'h1234 -> entry 2 stays 0 and `valid_mask[2]`=0.
- Full write then readback: write 16'hABCD to addr 0 and 16'h5A5A to addr 3 (`wr_be`=2'b11). Next cycle set `rd_addr1`=0, `rd_addr2`=3 -> one edge later `rd_data1`=16'hABCD, `rd_data2`=16'h5A5A, and `valid_mask`=4'b1001.
- Byte-masked write: entry 1 = 16'h1122, then write 16'hFFEE with `wr_be`=2'b01 -> read gives 16'h11EE. A following write with `wr_be`=2'b00 leaves 16'h11EE.
- Same-edge read/write: entry 2 = 16'h0001, then write 16'h0002 to addr 2 while `rd_addr1`=`rd_addr2`=2 ->
  - with `REGFILE_BYPASS_EN`, both ports read 16'h0002;
  - without it, both read 16'h0001, and the next cycle both read 16'h0002.
- Parametric sweep: `DATA_W`=32, `ADDR_W`=3. Write addr k = 32'hC0DE0000+k for k=0..7 with `wr_be`=4'hF, then read pairs (k, 7-k) -> the matching values are returned, and `valid_mask`=8'hFF.
